stack_ctx_ctrl: RTL and testbench

- Sequencer and guard in front of the CPU hardware stack (32-bit, 128-word, push/pop only).
- Passes single push/pop operations from the CPU pipeline and tracks stack depth.
- Blocks operations that would overflow or underflow the stack, and raises sticky error flags.
- Runs multi-word context save (register file to stack) and context restore (stack to register file) bursts for interrupt entry/exit.

---
 rtl/stack_ctx_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_stack_ctx_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctx_ctrl.sv
// stack_ctx_ctrl: guard and burst sequencer in front of the CPU hardware stack.
// Forwards single push/pop requests from the pipeline and blocks any operation
// that would overflow or underflow the stack, setting sticky error flags.
// It also runs context save (r1..rN -> stack) and context restore
// (stack -> rN..r1) bursts for interrupt entry and exit.
module stack_ctx_ctrl #(
  parameter int DEPTH = 128,
  parameter int DW    = 32,
  parameter int PTR_W = 8,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_push,
  input  logic             cpu_pop,
  input  logic [DW-1:0]    cpu_d,
  output logic [DW-1:0]    cpu_q,
  input  logic             ctx_save,
  input  logic             ctx_restore,
  input  logic [RA_W-1:0]  ctx_count,
  output logic [RA_W-1:0]  reg_raddr,
  input  logic [DW-1:0]    reg_rdata,
  output logic             reg_we,
  output logic [RA_W-1:0]  reg_waddr,
  output logic [DW-1:0]    reg_wdata,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [DW-1:0]    stk_d,
  input  logic [DW-1:0]    stk_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [PTR_W-1:0] depth,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  // The burst counter runs from 1 to N+1, so it needs one bit more than N.
  localparam int CNT_W = RA_W + 1;
  localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  n_q, n_d;
  logic             rej_q, rej_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             set_ovf_s;
  logic             set_unf_s;
  logic [PTR_W:0]   depth_ext_s;
  logic [PTR_W:0]   count_ext_s;
  logic [CNT_W-1:0] n_cnt_s;
  logic [CNT_W-1:0] waddr_full_s;

  logic             stk_push_s;
  logic             stk_pop_s;
  logic [DW-1:0]    stk_d_s;
  logic [RA_W-1:0]  reg_raddr_s;
  logic             reg_we_s;
  logic [RA_W-1:0]  reg_waddr_s;
  logic [DW-1:0]    reg_wdata_s;
  logic             busy_s;
  logic             done_s;
  logic             err_s;

  assign depth_ext_s  = {1'b0, depth_q};
  assign count_ext_s  = (PTR_W + 1)'(ctx_count);
  assign n_cnt_s      = CNT_W'(n_q);
  // Restore writes go to N, N-1, ..., 1 as the counter steps from 2 to N+1.
  assign waddr_full_s = n_cnt_s + CNT_W'(2) - cnt_q;

  // Next-state, depth tracking, error detection and stack/register-file strobes.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    rej_d       = rej_q;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    stk_push_s  = 1'b0;
    stk_pop_s   = 1'b0;
    stk_d_s     = '0;
    reg_raddr_s = '0;
    reg_we_s    = 1'b0;
    reg_waddr_s = '0;
    reg_wdata_s = '0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        rej_d = 1'b0;
        if (ctx_save) begin
          n_d   = ctx_count;
          cnt_d = CNT_W'(1);
          if ((depth_ext_s + count_ext_s) > DEPTH_EXT) begin
            state_d   = S_FINISH;
            rej_d     = 1'b1;
            set_ovf_s = 1'b1;
          end else if (ctx_count == RA_W'(0)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_SAVE;
          end
        end else if (ctx_restore) begin
          n_d   = ctx_count;
          cnt_d = CNT_W'(1);
          if (count_ext_s > depth_ext_s) begin
            state_d   = S_FINISH;
            rej_d     = 1'b1;
            set_unf_s = 1'b1;
          end else if (ctx_count == RA_W'(0)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_RESTORE;
          end
        end else if (cpu_push) begin
          if (depth_ext_s < DEPTH_EXT) begin
            stk_push_s = 1'b1;
            stk_d_s    = cpu_d;
          end else begin
            set_ovf_s = 1'b1;
          end
        end else if (cpu_pop) begin
          if (depth_q != PTR_W'(0)) begin
            stk_pop_s = 1'b1;
          end else begin
            set_unf_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SAVE: begin
        busy_s = 1'b1;
        // Reads lead the pushes by one cycle to cover register-file latency.
        if (cnt_q <= n_cnt_s) begin
          reg_raddr_s = cnt_q[RA_W-1:0];
        end else begin
          reg_raddr_s = '0;
        end
        if (cnt_q >= CNT_W'(2)) begin
          stk_push_s = 1'b1;
          stk_d_s    = reg_rdata;
        end else begin
          stk_push_s = 1'b0;
        end
        if (cnt_q == (n_cnt_s + CNT_W'(1))) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESTORE: begin
        busy_s = 1'b1;
        // Pops lead the writes by one cycle; stack data is valid after the pop.
        if (cnt_q <= n_cnt_s) begin
          stk_pop_s = 1'b1;
        end else begin
          stk_pop_s = 1'b0;
        end
        if (cnt_q >= CNT_W'(2)) begin
          reg_we_s    = 1'b1;
          reg_waddr_s = waddr_full_s[RA_W-1:0];
          reg_wdata_s = stk_q;
        end else begin
          reg_we_s = 1'b0;
        end
        if (cnt_q == (n_cnt_s + CNT_W'(1))) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FINISH: begin
        done_s  = 1'b1;
        err_s   = rej_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Guards above ensure the counter never wraps; push and pop are exclusive.
    if (stk_push_s) begin
      depth_d = depth_q + PTR_W'(1);
    end else if (stk_pop_s) begin
      depth_d = depth_q - PTR_W'(1);
    end else begin
      depth_d = depth_q;
    end
  end

  // Sticky flags: err_clr clears them, but a new error in the same cycle wins.
  always_comb begin
    overflow_d  = (overflow_q  & ~err_clr) | set_ovf_s;
    underflow_d = (underflow_q & ~err_clr) | set_unf_s;
  end

  // State, counters and flags; synchronous active-low reset abandons any burst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      rej_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      rej_q       <= rej_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Strobes are held low while reset is asserted so nothing leaks to the stack.
  assign stk_push  = reset & stk_push_s;
  assign stk_pop   = reset & stk_pop_s;
  assign stk_d     = reset ? stk_d_s : '0;
  assign reg_raddr = reset ? reg_raddr_s : '0;
  assign reg_we    = reset & reg_we_s;
  assign reg_waddr = reset ? reg_waddr_s : '0;
  assign reg_wdata = reset ? reg_wdata_s : '0;
  assign busy      = reset & busy_s;
  assign done      = reset & done_s;
  assign err       = reset & err_s;
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign cpu_q     = stk_q;

endmodule

// File: tb/tb_stack_ctx_ctrl.sv
// Directed testbench for stack_ctx_ctrl with a behavioural stack and register file.
module tb_stack_ctx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_push = 1'b0, cpu_pop = 1'b0;
  logic [31:0] cpu_d = 32'd0;
  logic [31:0] cpu_q;
  logic        ctx_save = 1'b0, ctx_restore = 1'b0;
  logic [3:0]  ctx_count = 4'd0;
  logic [3:0]  reg_raddr;
  logic [31:0] reg_rdata;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        stk_push, stk_pop;
  logic [31:0] stk_d;
  logic [31:0] stk_q;
  logic        busy, done, err;
  logic [7:0]  depth;
  logic        overflow, underflow;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Bench-side register-file preload port.
  logic        rf_set = 1'b0;
  logic [3:0]  rf_addr = 4'd0;
  logic [31:0] rf_val = 32'd0;

  logic [31:0] mem [128];
  int          sp;
  logic [31:0] q_r;
  logic [31:0] rf [16];
  logic [31:0] rdata_r;

  assign stk_q = q_r;
  assign reg_rdata = rdata_r;

  stack_ctx_ctrl dut (
    .clk(clk), .reset(reset), .cpu_push(cpu_push), .cpu_pop(cpu_pop),
    .cpu_d(cpu_d), .cpu_q(cpu_q), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .ctx_count(ctx_count), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d), .stk_q(stk_q),
    .busy(busy), .done(done), .err(err), .depth(depth),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stack model: shares the reset; output valid the cycle after a pop.
  always @(posedge clk) begin
    if (!reset) begin
      sp  <= 0;
      q_r <= 32'd0;
    end else if (stk_push && sp < 128) begin
      mem[sp] <= stk_d;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      q_r <= mem[sp-1];
      sp  <= sp - 1;
    end
  end

  // Register-file model: one-cycle read latency, bench preload or DUT write.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      rdata_r <= rf[reg_raddr];
      if (rf_set) rf[rf_addr] <= rf_val;
      else if (reg_we) rf[reg_waddr] <= reg_wdata;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; cpu_push = 1'b0; cpu_pop = 1'b0; ctx_save = 1'b0;
    ctx_restore = 1'b0; err_clr = 1'b0; rf_set = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_push = 1'b1; cpu_d = base + 32'(i);
    end
    @(negedge clk);
    cpu_push = 1'b0;
  endtask

  task automatic set_regs(input logic [31:0] base);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rf_set = 1'b1; rf_addr = 4'(i); rf_val = base + 32'(i);
    end
    @(negedge clk);
    rf_set = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; cpu_push = 1'b1; cpu_d = 32'h77;
    @(negedge clk);
    #1;
    n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL reset_push got %0b want 0", stk_push); end
    n_checks++; if (depth !== 8'd0) begin n_fail++; $display("FAIL reset_depth got %0d want 0", depth); end
    n_checks++; if ({busy, done, err, overflow, underflow} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {busy, done, err, overflow, underflow}); end
    cpu_push = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_q [3];
    exp_q[0] = 32'hC; exp_q[1] = 32'hB; exp_q[2] = 32'hA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_push = 1'b1; cpu_d = 32'hA + 32'(i);
      #1;
      n_checks++; if (stk_push !== 1'b1 || stk_d !== 32'hA + 32'(i)) begin n_fail++; $display("FAIL push_strobe got %0b/%h want 1/%h", stk_push, stk_d, 32'hA + 32'(i)); end
    end
    @(negedge clk);
    cpu_push = 1'b0;
    n_checks++; if (depth !== 8'd3) begin n_fail++; $display("FAIL push_depth got %0d want 3", depth); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (cpu_q !== exp_q[i-1]) begin n_fail++; $display("FAIL pop_data got %h want %h", cpu_q, exp_q[i-1]); end
      end
      cpu_pop = 1'b1;
      #1;
      n_checks++; if (stk_pop !== 1'b1) begin n_fail++; $display("FAIL pop_strobe got %0b want 1", stk_pop); end
    end
    @(negedge clk);
    n_checks++; if (cpu_q !== exp_q[2]) begin n_fail++; $display("FAIL pop_data got %h want %h", cpu_q, exp_q[2]); end
    n_checks++; if (depth !== 8'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL pop_end got d=%0d o=%0b u=%0b want 0/0/0", depth, overflow, underflow); end
    // Pop on an empty stack is blocked and flagged.
    #1;
    n_checks++; if (stk_pop !== 1'b0) begin n_fail++; $display("FAIL empty_pop got %0b want 0", stk_pop); end
    @(negedge clk);
    cpu_pop = 1'b0;
    n_checks++; if (underflow !== 1'b1 || depth !== 8'd0) begin n_fail++; $display("FAIL underflow_set got u=%0b d=%0d want 1/0", underflow, depth); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clr got %0b want 0", underflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    push_n(128, 32'h1000);
    n_checks++; if (depth !== 8'd128) begin n_fail++; $display("FAIL fill_depth got %0d want 128", depth); end
    cpu_push = 1'b1; cpu_d = 32'hBAD;
    #1;
    n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL full_push got %0b want 0", stk_push); end
    @(negedge clk);
    n_checks++; if (overflow !== 1'b1 || depth !== 8'd128) begin n_fail++; $display("FAIL overflow_set got o=%0b d=%0d want 1/128", overflow, depth); end
    // Clear coincides with a fresh overflow: the new error wins.
    err_clr = 1'b1;
    @(negedge clk);
    cpu_push = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_new got %0b want 1", overflow); end
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0 || depth !== 8'd128) begin n_fail++; $display("FAIL overflow_clr got o=%0b d=%0d want 0/128", overflow, depth); end
  endtask

  task automatic test_save_restore();
    do_reset();
    push_n(10, 32'h100);
    set_regs(32'd0);
    ctx_save = 1'b1; ctx_count = 4'd4;
    @(negedge clk);
    ctx_save = 1'b0;
    n_checks++; if (busy !== 1'b1 || reg_raddr !== 4'd1 || stk_push !== 1'b0) begin n_fail++; $display("FAIL save_t1 got b=%0b ra=%0d p=%0b want 1/1/0", busy, reg_raddr, stk_push); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      n_checks++; if (stk_push !== 1'b1 || stk_d !== 32'(k-1) || busy !== 1'b1) begin n_fail++; $display("FAIL save_push t%0d got p=%0b d=%h b=%0b want 1/%h/1", k, stk_push, stk_d, busy, k-1); end
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || depth !== 8'd14) begin n_fail++; $display("FAIL save_done got dn=%0b e=%0b b=%0b d=%0d want 1/0/0/14", done, err, busy, depth); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL save_done_pulse got %0b want 0", done); end
    set_regs(32'hDEAD0000);
    ctx_restore = 1'b1; ctx_count = 4'd4;
    @(negedge clk);
    ctx_restore = 1'b0;
    n_checks++; if (stk_pop !== 1'b1 || reg_we !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rest_t1 got p=%0b we=%0b b=%0b want 1/0/1", stk_pop, reg_we, busy); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      n_checks++; if (reg_we !== 1'b1 || reg_waddr !== 4'(6-k) || reg_wdata !== 32'(6-k) || stk_pop !== (k < 5)) begin n_fail++; $display("FAIL rest_write t%0d got we=%0b wa=%0d wd=%h p=%0b want 1/%0d/%h/%0b", k, reg_we, reg_waddr, reg_wdata, stk_pop, 6-k, 6-k, k < 5); end
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || depth !== 8'd10) begin n_fail++; $display("FAIL rest_done got dn=%0b e=%0b d=%0d want 1/0/10", done, err, depth); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (rf[i] !== 32'(i)) begin n_fail++; $display("FAIL rest_reg r%0d got %h want %h", i, rf[i], i); end
    end
  endtask

  task automatic test_reject();
    do_reset();
    push_n(125, 32'h200);
    ctx_save = 1'b1; ctx_count = 4'd4;
    @(negedge clk);
    ctx_save = 1'b0;
    n_checks++; if (stk_push !== 1'b0 || done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL save_rej got p=%0b dn=%0b e=%0b b=%0b want 0/1/1/0", stk_push, done, err, busy); end
    n_checks++; if (overflow !== 1'b1 || depth !== 8'd125) begin n_fail++; $display("FAIL save_rej_flag got o=%0b d=%0d want 1/125", overflow, depth); end
    do_reset();
    push_n(2, 32'h300);
    ctx_restore = 1'b1; ctx_count = 4'd3;
    @(negedge clk);
    ctx_restore = 1'b0;
    n_checks++; if (stk_pop !== 1'b0 || done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL rest_rej got p=%0b dn=%0b e=%0b want 0/1/1", stk_pop, done, err); end
    n_checks++; if (underflow !== 1'b1 || depth !== 8'd2) begin n_fail++; $display("FAIL rest_rej_flag got u=%0b d=%0d want 1/2", underflow, depth); end
    @(negedge clk);
    ctx_save = 1'b1; ctx_count = 4'd0;
    @(negedge clk);
    ctx_save = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || stk_push !== 1'b0 || depth !== 8'd2) begin n_fail++; $display("FAIL save_n0 got dn=%0b e=%0b p=%0b d=%0d want 1/0/0/2", done, err, stk_push, depth); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctx_save = 1'b1; ctx_count = 4'd8; cpu_push = 1'b1; cpu_d = 32'h55;
    #1;
    n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL prio_push got %0b want 0", stk_push); end
    @(negedge clk);
    ctx_save = 1'b0; cpu_push = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (depth !== 8'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_save got d=%0d b=%0b want 2/1", depth, busy); end
    reset = 1'b0;
    #1;
    n_checks++; if (stk_push !== 1'b0) begin n_fail++; $display("FAIL reset_gate got %0b want 0", stk_push); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (depth !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || stk_push !== 1'b0) begin n_fail++; $display("FAIL abort got d=%0d b=%0b dn=%0b p=%0b want 0/0/0/0", depth, busy, done, stk_push); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || stk_push !== 1'b0) begin n_fail++; $display("FAIL no_done got dn=%0b p=%0b want 0/0", done, stk_push); end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_save_restore();
    test_reject();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
